// File: rtl/mem_pkg.sv
// ============================================================================
// Module      : mem_pkg
// Description : Shared M-control bit positions, control widths and FSM states
//               for the memory-access / write-back stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_pkg;

    localparam int M_MEMREAD  = 3;
    localparam int M_MEMWRITE = 2;
    localparam int M_BRANCH   = 1;

    localparam int CTRL_M_W   = 4;
    localparam int CTRL_WB_W  = 2;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/data_memory.sv
// ============================================================================
// Module      : data_memory
// Description : DEPTH x 32 word array, combinational read, synchronous write.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_memory #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_wdata,
    output logic [31:0]       o_rdata
);

    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            mem_q[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = mem_q[i_addr];

endmodule

`default_nettype wire

// File: rtl/mem_wb_stage.sv
// ============================================================================
// Module      : mem_wb_stage
// Description : Pipeline MEM stage: multi-cycle data-memory access with stall,
//               branch resolution and the MEM/WB register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_wb_stage
    import mem_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int MEM_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          result_in,
    input  logic [31:0]          write_data_in,
    input  logic [4:0]           reg_dest_in,
    input  logic [CTRL_M_W-1:0]  ctrl_m_in,
    input  logic [CTRL_WB_W-1:0] ctrl_wb_in,
    input  logic                 zero_in,
    output logic                 stall,
    output logic                 branch_taken,
    output logic [31:0]          read_data_out,
    output logic [31:0]          result_out,
    output logic [4:0]           reg_dest_out,
    output logic [CTRL_WB_W-1:0] ctrl_wb_out
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [31:0]          read_data_q, read_data_d;
    logic [31:0]          result_q, result_d;
    logic [4:0]           reg_dest_q, reg_dest_d;
    logic [CTRL_WB_W-1:0] ctrl_wb_q, ctrl_wb_d;

    logic                 w_access;
    logic                 w_commit;
    logic                 w_mem_we;
    logic [ADDR_W-1:0]    w_idx;
    logic [31:0]          w_rdata;
    logic                 w_unused;

    assign w_access = ctrl_m_in[M_MEMREAD] | ctrl_m_in[M_MEMWRITE];
    assign w_idx    = result_in[ADDR_W+1:2];
    assign w_unused = ^{result_in[31:ADDR_W+2], result_in[1:0], ctrl_m_in[0]};

    assign branch_taken = ctrl_m_in[M_BRANCH] & zero_in;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (w_access && (MEM_LATENCY > 1)) begin
                    stall   = 1'b1;
                    state_d = BUSY;
                    cnt_d   = CNT_W'(MEM_LATENCY - 2);
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    stall = 1'b1;
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (rst) begin
            stall = 1'b0;
        end
    end

    // Reset aborts an in-flight access, so the write enable must also see rst.
    assign w_commit = ~stall & ~rst;
    assign w_mem_we = w_commit & ctrl_m_in[M_MEMWRITE];

    data_memory #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_data_memory (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_addr  (w_idx),
        .i_wdata (write_data_in),
        .o_rdata (w_rdata)
    );

    always_comb begin
        read_data_d = read_data_q;
        result_d    = result_q;
        reg_dest_d  = reg_dest_q;
        ctrl_wb_d   = ctrl_wb_q;
        if (stall) begin
            ctrl_wb_d = '0;
        end else begin
            ctrl_wb_d   = ctrl_wb_in;
            result_d    = result_in;
            reg_dest_d  = reg_dest_in;
            read_data_d = ctrl_m_in[M_MEMREAD] ? w_rdata : 32'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            read_data_q <= '0;
            result_q    <= '0;
            reg_dest_q  <= '0;
            ctrl_wb_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            read_data_q <= read_data_d;
            result_q    <= result_d;
            reg_dest_q  <= reg_dest_d;
            ctrl_wb_q   <= ctrl_wb_d;
        end
    end

    assign read_data_out = read_data_q;
    assign result_out    = result_q;
    assign reg_dest_out  = reg_dest_q;
    assign ctrl_wb_out   = ctrl_wb_q;

endmodule

`default_nettype wire
